// File: rtl/sparse_dp_row_acc.sv
// Purpose: row of M N:M structured-sparse dot-product columns with a weight-stationary buffer, accumulating one result per tile.
// Latency: 1 beat/cycle within a tile; last beat accepted in cycle t -> out_valid in cycle t+2.
// Backpressure: act_ready drops through FLUSH/OUT; the result is held stable in OUT until out_ready.
//
// Ports: clk/reset (async, active-low); nnz_sel (active nonzeros per group, latched at tile start);
//   w_wr/w_col/w_addr/w_data/w_idx (weight buffer write, honoured only in IDLE);
//   act_valid/act_ready/act_data/act_last (activation beat stream); psum_in (per-column initial value);
//   out_valid/out_ready/psum_out (tile result); busy (tile in progress).
// Build option: define DPROW_SAT_EN to saturate accumulator updates instead of wrapping.
module sparse_dp_row_acc #(
    parameter int bw      = 4,
    parameter int psum_bw = 20,
    parameter int n       = 4,
    parameter int nnz_max = 2,
    parameter int M       = 4,
    parameter int DEPTH   = 8
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [$clog2(nnz_max+1)-1:0]        nnz_sel,
    input  logic                                w_wr,
    input  logic [$clog2(M)-1:0]                w_col,
    input  logic [$clog2(DEPTH)-1:0]            w_addr,
    input  logic [nnz_max*bw-1:0]               w_data,
    input  logic [nnz_max*$clog2(n)-1:0]        w_idx,
    input  logic                                act_valid,
    output logic                                act_ready,
    input  logic [n*bw-1:0]                     act_data,
    input  logic                                act_last,
    input  logic [M*psum_bw-1:0]                psum_in,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [M*psum_bw-1:0]                psum_out,
    output logic                                busy
);

    localparam int IW  = $clog2(n);
    localparam int NSW = $clog2(nnz_max+1);
    localparam int AW  = $clog2(DEPTH);
    localparam int PW  = 2*bw + 1;                    // signed weight x zero-extended activation
    localparam int SW  = PW + $clog2(nnz_max+1);      // per-beat column sum, no overflow

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_OUT} state_t;

    state_t state_q, state_d;

    // Weight buffer is deliberately not reset.
    logic [nnz_max*bw-1:0] w_mem_dat [M][DEPTH];
    logic [nnz_max*IW-1:0] w_mem_idx [M][DEPTH];

    logic                      ready_en_q;     // keeps act_ready low until the first edge after reset
    logic [AW-1:0]             cnt_q;
    logic [NSW-1:0]            nnz_q;
    logic                      prod_vld_q;
    logic signed [SW-1:0]      prod_q [M];
    logic signed [psum_bw-1:0] acc_q  [M];

    logic                      beat_acc;
    logic                      beat_last;
    logic [AW-1:0]             rd_addr;
    logic [NSW-1:0]            nnz_in_c;
    logic [NSW-1:0]            nnz_eff;
    logic signed [SW-1:0]      sum_c [M];

    function automatic logic signed [PW-1:0] mul(input logic signed [bw-1:0] w,
                                                 input logic [bw-1:0] a);
        return w * $signed({1'b0, a});
    endfunction

    function automatic logic [bw-1:0] act_elem(input logic [n*bw-1:0] a,
                                               input logic [IW-1:0] j);
        return a[int'(j)*bw +: bw];
    endfunction

`ifdef DPROW_SAT_EN
    localparam int XW = ((SW > psum_bw) ? SW : psum_bw) + 1;
    localparam logic signed [XW-1:0] ACC_MAX = {{(XW-psum_bw+1){1'b0}}, {(psum_bw-1){1'b1}}};
    localparam logic signed [XW-1:0] ACC_MIN = ~ACC_MAX;

    function automatic logic signed [psum_bw-1:0] acc_add(input logic signed [psum_bw-1:0] a,
                                                          input logic signed [SW-1:0] b);
        logic signed [XW-1:0] s;
        s = XW'(a) + XW'(b);
        if (s > ACC_MAX)      return ACC_MAX[psum_bw-1:0];
        else if (s < ACC_MIN) return ACC_MIN[psum_bw-1:0];
        else                  return s[psum_bw-1:0];
    endfunction
`else
    function automatic logic signed [psum_bw-1:0] acc_add(input logic signed [psum_bw-1:0] a,
                                                          input logic signed [SW-1:0] b);
        return a + psum_bw'(b);
    endfunction
`endif

    assign act_ready = ready_en_q && (state_q == S_IDLE || state_q == S_RUN);
    assign beat_acc  = act_valid && act_ready;

    // The first beat of a tile always reads entry 0; later beats use the running count.
    assign rd_addr   = (state_q == S_RUN) ? cnt_q : '0;
    assign beat_last = act_last || (DEPTH == 1) ||
                       (state_q == S_RUN && cnt_q == AW'(DEPTH-1));

    // The first beat uses the live selector because the latched copy is not loaded yet.
    assign nnz_in_c  = (int'(nnz_sel) > nnz_max) ? NSW'(nnz_max) : nnz_sel;
    assign nnz_eff   = (state_q == S_IDLE) ? nnz_in_c : nnz_q;

    always_comb begin
        for (int i = 0; i < M; i++) begin
            sum_c[i] = '0;
            for (int k = 0; k < nnz_max; k++) begin
                if (k < int'(nnz_eff)) begin
                    sum_c[i] = sum_c[i] + SW'(mul(w_mem_dat[i][rd_addr][k*bw +: bw],
                                                  act_elem(act_data, w_mem_idx[i][rd_addr][k*IW +: IW])));
                end
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        out_valid = 1'b0;
        busy      = (state_q != S_IDLE);
        case (state_q)
            S_IDLE:  if (beat_acc) state_d = beat_last ? S_FLUSH : S_RUN;
            S_RUN:   if (beat_acc && beat_last) state_d = S_FLUSH;
            S_FLUSH: state_d = S_OUT;
            S_OUT: begin
                out_valid = 1'b1;
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ready_en_q <= 1'b0;
            cnt_q      <= '0;
            nnz_q      <= '0;
            prod_vld_q <= 1'b0;
            for (int i = 0; i < M; i++) begin
                prod_q[i] <= '0;
                acc_q[i]  <= '0;
            end
        end else begin
            ready_en_q <= 1'b1;
            prod_vld_q <= beat_acc;
            if (beat_acc) begin
                cnt_q <= (state_q == S_IDLE) ? AW'(1) : cnt_q + AW'(1);
                for (int i = 0; i < M; i++) prod_q[i] <= sum_c[i];
            end
            if (beat_acc && state_q == S_IDLE) begin
                nnz_q <= nnz_in_c;
                for (int i = 0; i < M; i++) acc_q[i] <= psum_in[i*psum_bw +: psum_bw];
            end else if (prod_vld_q) begin
                for (int i = 0; i < M; i++) acc_q[i] <= acc_add(acc_q[i], prod_q[i]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr && state_q == S_IDLE) begin
            w_mem_dat[w_col][w_addr] <= w_data;
            w_mem_idx[w_col][w_addr] <= w_idx;
        end
    end

    always_comb begin
        for (int i = 0; i < M; i++) psum_out[i*psum_bw +: psum_bw] = acc_q[i];
    end

endmodule

// File: tb/tb_sparse_dp_row_acc.sv
module tb_sparse_dp_row_acc;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [1:0]  nnz_sel;
    logic        w_wr;
    logic [1:0]  w_col;
    logic [2:0]  w_addr;
    logic [7:0]  w_data;
    logic [3:0]  w_idx;
    logic        act_valid, act_ready, act_last;
    logic [15:0] act_data;
    logic [79:0] psum_in, psum_out;
    logic        out_valid, out_ready, busy;
    // Narrow-accumulator instance shares every input except psum_in.
    logic [31:0] psum_in2, psum_out2;
    logic        act_ready2, out_valid2, busy2;

    int tests_run = 0;
    int tests_failed = 0;

    sparse_dp_row_acc dut (
        .clk(clk), .reset(reset), .nnz_sel(nnz_sel), .w_wr(w_wr), .w_col(w_col),
        .w_addr(w_addr), .w_data(w_data), .w_idx(w_idx), .act_valid(act_valid),
        .act_ready(act_ready), .act_data(act_data), .act_last(act_last),
        .psum_in(psum_in), .out_valid(out_valid), .out_ready(out_ready),
        .psum_out(psum_out), .busy(busy)
    );

    sparse_dp_row_acc #(.psum_bw(8)) dut8 (
        .clk(clk), .reset(reset), .nnz_sel(nnz_sel), .w_wr(w_wr), .w_col(w_col),
        .w_addr(w_addr), .w_data(w_data), .w_idx(w_idx), .act_valid(act_valid),
        .act_ready(act_ready2), .act_data(act_data), .act_last(act_last),
        .psum_in(psum_in2), .out_valid(out_valid2), .out_ready(out_ready),
        .psum_out(psum_out2), .busy(busy2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int col, input int addr, input logic [7:0] d, input logic [3:0] ix);
        w_wr = 1'b1; w_col = col[1:0]; w_addr = addr[2:0]; w_data = d; w_idx = ix;
        tick();
        w_wr = 1'b0;
    endtask

    task automatic beat(input logic [15:0] a, input logic last);
        act_valid = 1'b1; act_data = a; act_last = last;
        tick();
        act_valid = 1'b0; act_last = 1'b0;
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; nnz_sel = 2'd0; w_wr = 1'b0; w_col = '0; w_addr = '0; w_data = '0; w_idx = '0;
        act_valid = 1'b0; act_last = 1'b0; act_data = '0; psum_in = '0; psum_in2 = '0; out_ready = 1'b0;
        tick(); tick();
        tests_run++; if (act_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_act_ready: got %b want 0", act_ready); end
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", busy); end
        tests_run++; if (psum_out !== 80'd0) begin tests_failed++; $display("FAIL reset_psum_out: got %h want 0", psum_out); end
        reset = 1'b1;
        #1;
        tests_run++; if (act_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_release_ready_early: got %b want 0", act_ready); end
        tick();
        tests_run++; if (act_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_release_ready: got %b want 1", act_ready); end
        for (int c = 0; c < 4; c++)
            for (int a = 0; a < 8; a++) wr(c, a, 8'h00, 4'h0);
    endtask

    task automatic test_basic();
        int          nz [4] = '{2, 1, 0, 3};
        logic [19:0] ex [4] = '{20'd113, 20'd115, 20'd100, 20'd113};
        wr(0, 0, 8'hE3, 4'b1000);           // w=(3,-2) idx=(0,2)
        psum_in = 80'd100;
        for (int t = 0; t < 4; t++) begin
            nnz_sel = nz[t][1:0];
            tests_run++; if (act_ready !== 1'b1) begin tests_failed++; $display("FAIL basic_ready[%0d]: got %b want 1", t, act_ready); end
            beat(16'h9175, 1'b1);            // act=(5,7,1,9)
            tests_run++; if (out_valid !== 1'b0 || busy !== 1'b1) begin tests_failed++; $display("FAIL basic_flush[%0d]: valid=%b busy=%b want 0/1", t, out_valid, busy); end
            tick();
            tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL basic_valid[%0d]: got %b want 1", t, out_valid); end
            tests_run++; if (psum_out[19:0] !== ex[t]) begin tests_failed++; $display("FAIL basic_psum[%0d]: got %0d want %0d", t, psum_out[19:0], ex[t]); end
            handshake();
        end
    endtask

    task automatic test_multi_beat();
        for (int c = 0; c < 4; c++)
            for (int a = 0; a < 8; a++) wr(c, a, 8'h11, 4'b1101);   // w=(1,1) idx=(1,3)
        psum_in = '0;
        nnz_sel = 2'd2;
        beat(16'hFFFF, 1'b0);
        nnz_sel = 2'd0;                      // must not affect an in-flight tile
        beat(16'hFFFF, 1'b0);
        beat(16'hFFFF, 1'b0);
        beat(16'hFFFF, 1'b1);
        tests_run++; if (act_ready !== 1'b0) begin tests_failed++; $display("FAIL multi_ready_flush: got %b want 0", act_ready); end
        tick();
        tests_run++; if (act_ready !== 1'b0 || out_valid !== 1'b1) begin tests_failed++; $display("FAIL multi_out_state: ready=%b valid=%b want 0/1", act_ready, out_valid); end
        for (int c = 0; c < 4; c++) begin
            tests_run++; if (psum_out[c*20 +: 20] !== 20'd120) begin tests_failed++; $display("FAIL multi_psum[%0d]: got %0d want 120", c, psum_out[c*20 +: 20]); end
        end
        handshake();
        tests_run++; if (act_ready !== 1'b1 || out_valid !== 1'b0) begin tests_failed++; $display("FAIL multi_after_hs: ready=%b valid=%b want 1/0", act_ready, out_valid); end
    endtask

    task automatic test_forced_last();
        psum_in = '0;
        nnz_sel = 2'd2;
        for (int b = 0; b < 8; b++) begin
            tests_run++; if (act_ready !== 1'b1) begin tests_failed++; $display("FAIL forced_ready[%0d]: got %b want 1", b, act_ready); end
            beat(16'hFFFF, 1'b0);
        end
        act_valid = 1'b1;                    // 9th beat offered, must be held off
        tests_run++; if (act_ready !== 1'b0 || out_valid !== 1'b0) begin tests_failed++; $display("FAIL forced_flush: ready=%b valid=%b want 0/0", act_ready, out_valid); end
        tick();
        tests_run++; if (act_ready !== 1'b0 || out_valid !== 1'b1) begin tests_failed++; $display("FAIL forced_out: ready=%b valid=%b want 0/1", act_ready, out_valid); end
        tests_run++; if (psum_out[19:0] !== 20'd240 || psum_out[79:60] !== 20'd240) begin tests_failed++; $display("FAIL forced_psum: got %0d/%0d want 240", psum_out[19:0], psum_out[79:60]); end
        act_valid = 1'b0;
        handshake();
    endtask

    task automatic test_hold();
        psum_in = '0;
        nnz_sel = 2'd2;
        beat(16'h9175, 1'b1);                // col0 entry0 (1,1)/(1,3): 7+9
        tick();
        w_wr = 1'b1; w_col = 2'd0; w_addr = 3'd0; w_data = 8'h77; w_idx = 4'h0;
        for (int c = 0; c < 5; c++) begin
            tests_run++; if (out_valid !== 1'b1 || act_ready !== 1'b0) begin tests_failed++; $display("FAIL hold_ctrl[%0d]: valid=%b ready=%b want 1/0", c, out_valid, act_ready); end
            tests_run++; if (psum_out[19:0] !== 20'd16) begin tests_failed++; $display("FAIL hold_psum[%0d]: got %0d want 16", c, psum_out[19:0]); end
            tick();
        end
        w_wr = 1'b0;
        handshake();
        beat(16'h9175, 1'b1);
        tick();
        tests_run++; if (psum_out[19:0] !== 20'd16) begin tests_failed++; $display("FAIL hold_rerun: got %0d want 16", psum_out[19:0]); end
        handshake();
    endtask

    task automatic test_wrap();
        logic [7:0] wd  [2] = '{8'h01, 8'h0F};     // w0 = +1 / -1, slot1 = 0
        logic [7:0] pin [2] = '{8'd120, 8'h88};    // +120 / -120
`ifdef DPROW_SAT_EN
        logic [7:0] ex  [2] = '{8'h7F, 8'h80};
`else
        logic [7:0] ex  [2] = '{8'h87, 8'h79};
`endif
        logic [19:0] ex20 [2] = '{20'd15, 20'hFFFF1};
        for (int t = 0; t < 2; t++) begin
            wr(0, 0, wd[t], 4'h0);
            psum_in = '0;
            psum_in2 = {24'd0, pin[t]};
            nnz_sel = 2'd1;
            beat(16'h000F, 1'b1);
            tick();
            tests_run++; if (out_valid2 !== 1'b1 || psum_out2[7:0] !== ex[t]) begin tests_failed++; $display("FAIL wrap8[%0d]: valid=%b got %h want %h", t, out_valid2, psum_out2[7:0], ex[t]); end
            tests_run++; if (psum_out[19:0] !== ex20[t]) begin tests_failed++; $display("FAIL wrap20[%0d]: got %h want %h", t, psum_out[19:0], ex20[t]); end
            handshake();
        end
    endtask

    task automatic test_reset_mid();
        logic saw_valid = 1'b0;
        psum_in = '0;
        nnz_sel = 2'd2;
        beat(16'hFFFF, 1'b0);
        beat(16'hFFFF, 1'b0);
        tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL midrst_busy_before: got %b want 1", busy); end
        act_valid = 1'b1;
        reset = 1'b0;
        #1;
        tests_run++; if (act_ready !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin tests_failed++; $display("FAIL midrst_outputs: ready=%b busy=%b valid=%b want 0/0/0", act_ready, busy, out_valid); end
        tests_run++; if (psum_out !== 80'd0) begin tests_failed++; $display("FAIL midrst_psum: got %h want 0", psum_out); end
        act_valid = 1'b0;
        tick(); tick();
        reset = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (out_valid !== 1'b0) saw_valid = 1'b1;
        end
        tests_run++; if (saw_valid !== 1'b0) begin tests_failed++; $display("FAIL midrst_no_output: got %b want 0", saw_valid); end
        tests_run++; if (act_ready !== 1'b1 || busy !== 1'b0) begin tests_failed++; $display("FAIL midrst_recover: ready=%b busy=%b want 1/0", act_ready, busy); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_multi_beat();
        test_forced_last();
        test_hold();
        test_wrap();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/sparse_dp_row_acc.md
# sparse_dp_row_acc

Parametrised row of M structured-sparse (N:M) dot-product columns with a weight-stationary buffer, streaming activation input, per-tile accumulation and a ready/valid result port. Successor to the fixed single-vector sparse DP row. Adds run-time sparsity selection, multi-group tile accumulation over DEPTH activation beats, and backpressure. Sits between the activation SRAM streamer and the psum chain or output FIFO of the accelerator core.

## Interface
- bw, 4: activation and weight element width
- psum_bw, 20: accumulator / psum width
- n, 4: group size; must be a power of two; IW = clog2(n)
- nnz_max, 2: max nonzero weights per group per column
- M, 4: number of columns (output channels)
- DEPTH, 8: weight entries per column (max beats per tile)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low
- nnz_sel  in  clog2(nnz_max+1)  active nonzeros per group, sampled at tile start
- w_wr  in  1  weight write strobe
- w_col  in  clog2(M)  column select
- w_addr  in  clog2(DEPTH)  entry select
- w_data  in  nnz_max*bw  signed weights, slot k at [k*bw +: bw]
- w_idx  in  nnz_max*IW  in-group position of slot k
- act_valid  in  1  activation beat valid
- act_ready  out  1  activation beat accepted when valid&ready
- act_data  in  n*bw  unsigned activations, element j at [j*bw +: bw]
- act_last  in  1  final beat of tile
- psum_in  in  M*psum_bw  per-column initial value, sampled with first beat of tile
- out_valid  out  1  result valid
- out_ready  in  1  result consumer ready
- psum_out  out  M*psum_bw  column i at [i*psum_bw +: psum_bw]
- busy  out  1  high in RUN/FLUSH/OUT

## Operation
- States: IDLE, RUN, FLUSH, OUT.
- IDLE: w_wr writes entry (w_col, w_addr); act_ready=1. On first accepted beat: latch nnz_sel and psum_in into accumulators, beat counter=1, go RUN; if that beat has act_last, go FLUSH.
- RUN: act_ready=1; weight reads use beat counter as entry address. Beat with act_last, or DEPTH-th beat (forced last), goes to FLUSH.
- FLUSH: act_ready=0; one cycle for final product to accumulate; then OUT.
- OUT: out_valid=1, psum_out stable; on out_ready go IDLE.
- w_wr outside IDLE: ignored, buffer unchanged.
- Per beat, column i: sum over k < nnz_sel of w[i][addr][k] (signed) * act[w_idx[i][addr][k]] (unsigned, zero-extended). Slots k >= nnz_sel contribute 0. nnz_sel=0 gives 0. nnz_sel > nnz_max is clamped to nnz_max.
- Products are bw*2+1 signed. Sum is sign-extended to psum_bw. Accumulator wraps mod 2^psum_bw (default build).
- Duplicate indices in a group are legal; each slot contributes independently.

## Timing
- Reset (asserted low, async): state IDLE, act_ready=0, out_valid=0, busy=0, psum_out=0, accumulators=0, counter=0. Weight buffer is not cleared. act_ready=1 from first clk edge after release.
- Throughput: 1 beat/cycle within a tile.
- Pipeline: beat accepted cycle t → product register t+1 → accumulator updated at end of t+1.
- Latency: last beat accepted in cycle t → out_valid=1 in cycle t+2.
- act_ready returns to 1 the cycle after the out_valid&out_ready handshake. Minimum tile gap: 3 cycles.
- A weight write in the same cycle as the first beat of a tile is accepted, but its data is not guaranteed visible to that tile.
- Reset mid-tile aborts the tile. No output is produced.

## Configuration
- DPROW_SAT_EN defined: each accumulator update saturates to [-2^(psum_bw-1), 2^(psum_bw-1)-1]. This applies to the psum_in add, all beats and all columns.
- DPROW_SAT_EN undefined: two's-complement wrap.

## Test plan
- Column 0 entry 0: w=(3,-2), idx=(0,2). nnz_sel=2, act=(5,7,1,9), act_last, psum_in[0]=100 → psum_out[0]=113 at t+2.
- Same tile with nnz_sel=1 → psum_out[0]=115. With nnz_sel=0 → psum_out[0]=100.
- 4-beat tile, all columns w=(1,1), idx=(1,3), act=(15,15,15,15) each beat, psum_in=0 → every column 120. act_ready low for exactly FLUSH+OUT cycles.
- No act_last for 8 beats (DEPTH=8) → forced last after beat 8, out_valid 2 cycles later. The 9th beat is held off (act_ready=0).
- out_ready held low 5 cycles → out_valid and psum_out stable, act_ready=0 throughout. w_wr during this time is ignored, checked by a rerun.
- psum_bw=8, psum_in=120, product +15: wraps to -121 without DPROW_SAT_EN, 127 with it. Reset asserted mid-RUN → out_valid never rises, act_ready=0 immediately.
